sa_seq_ctrl: RTL and testbench

Sequencer for the N×N output-stationary systolic array. It accepts K unskewed operand slices, one A column and one B row per slice, through a valid/ready stream. It skews the slices onto the array's west (a) and north (b) edges, clears the array before each job, waits out the drain latency, then captures and presents the N×N result tile with a handshake. It sits between the operand buffers and the array instance in the matmul tile.

---
 rtl/sa_pkg.sv | 11 +
 rtl/sa_skew_line.sv | 23 ++
 rtl/sa_seq_ctrl.sv | 88 ++++++++
 tb/tb_sa_seq_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/sa_pkg.sv
// sa_pkg: states, lane/edge/tile types and the drain-latency helper for the systolic-array sequencer
package sa_pkg;
   localparam int SA_N = 32;
   typedef enum logic [2:0] {IDLE, CLEAR, STREAM, DRAIN, RESULT} sa_seq_state_t;
   typedef logic [7:0] lane_t;
   typedef lane_t [SA_N-1:0] edge_t;
   typedef edge_t [SA_N-1:0] tile_t;
   function automatic int drain_cyc(input int n, input int pe_lat);
      return 2 * n - 1 + pe_lat;
   endfunction
endpackage

// File: rtl/sa_skew_line.sv
// sa_skew_line: triangular delay line, lane i delayed i cycles, lane 0 combinational
module sa_skew_line
   import sa_pkg::*;
#(
   parameter int N = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  lane_t [N-1:0] d,
   output lane_t [N-1:0] q
);
   assign q[0] = d[0];
   for (genvar g = 1; g < N; g++) begin : g_lane
      lane_t [g-1:0] sr;
      logic [8*g+7:0] cat;
      assign cat = {sr, d[g]};
      assign q[g] = cat[8*g+7:8*g];
      always_ff @(posedge clk) begin
         if (rst) sr <= '0;
         else sr <= cat[8*g-1:0];
      end
   end
endmodule

// File: rtl/sa_seq_ctrl.sv
// sa_seq_ctrl: clears, feeds (skewed), drains and captures one job of the NxN output-stationary array.
// Optional SA_SEQ_PERF_EN adds bubble_cnt/job_cyc performance counters.
module sa_seq_ctrl
   import sa_pkg::*;
#(
   parameter int N      = 32,
   parameter int KW     = 16,
   parameter int PE_LAT = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [KW-1:0]            k_len,
   output logic                     busy,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [N-1:0][7:0]        in_a,
   input  logic [N-1:0][7:0]        in_b,
   output logic                     sa_rst,
   output logic [N-1:0][7:0]        sa_a,
   output logic [N-1:0][7:0]        sa_b,
   input  logic [N-1:0][N-1:0][7:0] sa_c,
   output logic [N-1:0][N-1:0][7:0] c_out,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     done
`ifdef SA_SEQ_PERF_EN
   ,
   output logic [KW-1:0]            bubble_cnt,
   output logic [31:0]              job_cyc
`endif
);
   localparam int DRAIN_CYC = drain_cyc(N, PE_LAT);
   localparam int DW = $clog2(DRAIN_CYC + 1);
   sa_seq_state_t state, nxt;
   logic [KW-1:0] kcnt;
   logic [DW-1:0] dcnt;
   logic hs, drain_end;
   logic [N-1:0][7:0] ga, gb;
   assign hs = (state == STREAM) && in_valid;
   assign drain_end = (state == DRAIN) && (dcnt == DW'(DRAIN_CYC - 1));
   // bubbles feed zero lanes so the array keeps its fixed timing
   assign ga = hs ? in_a : '0;
   assign gb = hs ? in_b : '0;
   sa_skew_line #(.N(N)) u_skew_a (.clk(clk), .rst(rst), .d(ga), .q(sa_a));
   sa_skew_line #(.N(N)) u_skew_b (.clk(clk), .rst(rst), .d(gb), .q(sa_b));
   always_comb begin
      nxt = state;
      busy = state != IDLE;
      in_ready = state == STREAM;
      sa_rst = rst || state == CLEAR;
      out_valid = state == RESULT;
      done = (state == RESULT) && out_ready && !rst;
      case (state)
         IDLE:    if (start) nxt = CLEAR;
         CLEAR:   nxt = (kcnt != '0) ? STREAM : DRAIN;
         STREAM:  if (hs && kcnt == KW'(1)) nxt = DRAIN;
         DRAIN:   if (drain_end) nxt = RESULT;
         RESULT:  if (out_ready) nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         kcnt <= '0;
         dcnt <= '0;
         c_out <= '0;
      end else begin
         state <= nxt;
         if (state == IDLE && start) kcnt <= k_len;
         else if (hs) kcnt <= kcnt - 1'b1;
         dcnt <= (state == DRAIN) ? dcnt + 1'b1 : '0;
         if (drain_end) c_out <= sa_c;
      end
   end
`ifdef SA_SEQ_PERF_EN
   always_ff @(posedge clk) begin
      if (rst || (state == IDLE && start)) begin
         bubble_cnt <= '0;
         job_cyc <= '0;
      end else begin
         if (state == STREAM && !in_valid) bubble_cnt <= bubble_cnt + 1'b1;
         if (state != IDLE) job_cyc <= job_cyc + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_sa_seq_ctrl.sv
// tb_sa_seq_ctrl: directed jobs against a behavioural 4x4 array with a result scoreboard
module tb_sa_seq_ctrl;
   localparam int N = 4;
   localparam int KW = 16;
   logic clk = 0;
   logic rst = 1;
   logic start = 0;
   logic in_valid = 0;
   logic out_ready = 0;
   logic [KW-1:0] k_len = '0;
   logic [N-1:0][7:0] in_a = '0;
   logic [N-1:0][7:0] in_b = '0;
   logic [N-1:0][7:0] sa_a, sa_b;
   logic [N-1:0][N-1:0][7:0] sa_c, c_out, ar, br, acc;
   logic busy, in_ready, sa_rst, out_valid, done;
   logic [N-1:0][7:0] av [8];
   logic [N-1:0][7:0] bv [8];
   logic [N-1:0][N-1:0][7:0] sb [$];
   logic [15:0] sa3 [64];
   int cyc = 0, checks = 0, errors = 0, ir_cnt = 0, done_cnt = 0, hs_cyc = 0;
`ifdef SA_SEQ_PERF_EN
   logic [KW-1:0] bubble_cnt;
   logic [31:0] job_cyc;
`endif

   sa_seq_ctrl #(.N(N), .KW(KW), .PE_LAT(1)) dut (
      .clk(clk), .rst(rst), .start(start), .k_len(k_len), .busy(busy),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
      .sa_rst(sa_rst), .sa_a(sa_a), .sa_b(sa_b), .sa_c(sa_c), .c_out(c_out),
      .out_valid(out_valid), .out_ready(out_ready), .done(done)
`ifdef SA_SEQ_PERF_EN
      , .bubble_cnt(bubble_cnt), .job_cyc(job_cyc)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // behavioural output-stationary array: operands hop one PE per cycle, acc updates one cycle after arrival
   function automatic logic [7:0] west(input int i, input int j);
      return (j == 0) ? sa_a[i] : ar[i][j-1];
   endfunction
   function automatic logic [7:0] north(input int i, input int j);
      return (i == 0) ? sa_b[j] : br[i-1][j];
   endfunction
   always @(posedge clk)
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            ar[i][j] <= sa_rst ? 8'd0 : west(i, j);
            br[i][j] <= sa_rst ? 8'd0 : north(i, j);
            acc[i][j] <= sa_rst ? 8'd0 : 8'(acc[i][j] + west(i, j) * north(i, j));
         end
   assign sa_c = acc;

   always @(negedge clk) begin
      ir_cnt <= ir_cnt + int'(in_ready);
      done_cnt <= done_cnt + int'(done);
      if (in_valid && in_ready) hs_cyc <= cyc;
      sa3[cyc % 64] <= {sa_a[3], sa_b[3]};
   end

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic fill_rand(input int k);
      for (int s = 0; s < k; s++) begin
         av[s] = {$urandom, $urandom};
         bv[s] = {$urandom, $urandom};
      end
   endtask

   // runs one job from a cycle just after a clock edge with the DUT idle
   task automatic job(input int k, input bit bub, input int lat, input int hold, input bit poke);
      logic [N-1:0][N-1:0][7:0] e, q0;
      int c0, n, s, t;
      e = '0;
      for (int kk = 0; kk < k; kk++)
         for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
               e[i][j] = e[i][j] + av[kk][i] * bv[kk][j];
      sb.push_back(e);
      start = 1;
      k_len = KW'(k);
      c0 = cyc;
      @(posedge clk);
      #1 start = 0;
      chk("clear_state", {sa_rst, busy, in_ready}, 3'b110);
      @(posedge clk);
      #1;
      n = 0;
      s = 0;
      while (n < k && s < 64) begin
         in_valid = !(bub && s % 2 == 0);
         in_a = av[n];
         in_b = bv[n];
         @(negedge clk);
         if (in_valid && in_ready) n++;
         @(posedge clk);
         #1 s++;
      end
      in_valid = 0;
      in_a = '0;
      in_b = '0;
      t = 0;
      @(negedge clk);
      while (!out_valid && t < 100) begin
         @(negedge clk);
         t++;
      end
      chk("out_valid_seen", out_valid, 1);
      chk("latency", cyc - c0, lat);
      q0 = sb.pop_front();
      chk("c_out", c_out, q0);
      for (int h = 0; h < hold; h++) begin
         @(posedge clk);
         #1 start = poke && h == 3;
         @(negedge clk);
         chk("hold", {out_valid, done, c_out}, {1'b1, 1'b0, q0});
      end
      @(posedge clk);
      #1 out_ready = 1;
      start = poke;
      @(negedge clk);
      chk("done_pulse", {done, out_valid}, 2'b11);
      @(posedge clk);
      #1 out_ready = 0;
      start = 0;
      @(negedge clk);
      chk("back_idle", {busy, out_valid, done}, 3'b000);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int h, ir0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_sa_rst", sa_rst, 1);
      chk("rst_outs", {busy, in_ready, out_valid, done}, 4'b0000);
      chk("rst_c_out", c_out, 0);
      chk("rst_skew", {sa_a, sa_b}, 0);
      @(posedge clk);
      #1 rst = 0;
      @(negedge clk);
      chk("sa_rst_low", {sa_rst, busy}, 2'b00);
      @(posedge clk);
      #1;
      // identity job: A = I, B[k][j] = 4k+j+1
      for (int kk = 0; kk < 4; kk++)
         for (int i = 0; i < N; i++) begin
            av[kk][i] = (i == kk) ? 8'd1 : 8'd0;
            bv[kk][i] = 8'(4 * kk + i + 1);
         end
      job(4, 0, 14, 0, 0);
      // single-slice skew check
      for (int i = 0; i < N; i++) begin
         av[0][i] = 8'(i + 1);
         bv[0][i] = 8'(i + 1);
      end
      job(1, 0, 11, 0, 0);
      h = hs_cyc;
      for (int d = 0; d < 6; d++)
         chk($sformatf("skew_lane3_d%0d", d), sa3[(h + d) % 64], (d == 3) ? 16'h0404 : 16'h0000);
      // identity again with a bubble before every slice
      for (int kk = 0; kk < 4; kk++)
         for (int i = 0; i < N; i++) begin
            av[kk][i] = (i == kk) ? 8'd1 : 8'd0;
            bv[kk][i] = 8'(4 * kk + i + 1);
         end
      job(4, 1, 18, 0, 0);
`ifdef SA_SEQ_PERF_EN
      chk("bubble_cnt", bubble_cnt, 4);
`endif
      // empty job never opens the input
      ir0 = ir_cnt;
      job(0, 0, 10, 0, 0);
      chk("k0_in_ready", ir_cnt, ir0);
      // back-pressure with start pokes, then an unrelated second job
      fill_rand(4);
      job(4, 0, 14, 10, 1);
      fill_rand(3);
      job(3, 0, 13, 0, 0);
      // reset during the third slice
      fill_rand(4);
      start = 1;
      k_len = 4;
      @(posedge clk);
      #1 start = 0;
      @(posedge clk);
      #1 in_valid = 1;
      in_a = av[0];
      in_b = bv[0];
      @(posedge clk);
      #1 in_a = av[1];
      in_b = bv[1];
      @(posedge clk);
      #1 in_a = av[2];
      in_b = bv[2];
      rst = 1;
      @(negedge clk);
      chk("mid_sa_rst", sa_rst, 1);
      @(posedge clk);
      #1 rst = 0;
      @(negedge clk);
      chk("mid_idle", {busy, out_valid, done, in_ready}, 4'b0000);
      chk("mid_skew", {sa_a, sa_b}, 0);
      @(posedge clk);
      #1 in_valid = 0;
      in_a = '0;
      in_b = '0;
      repeat (3) @(posedge clk);
      #1;
      fill_rand(4);
      job(4, 0, 14, 0, 0);
      chk("sb_empty", sb.size(), 0);
      chk("done_count", done_cnt, 7);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
